// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the clock-gate controller slice.
// Default latencies match the gating block's 2-stage synchroniser plus its gating latch.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned DEF_WAKE_LAT = 3;
    localparam int unsigned DEF_OFF_LAT  = 3;

    // Counter width able to hold LAT-1 (at least one bit).
    function automatic int unsigned lat_w(input int unsigned lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/clk_gate_lat_cnt.sv
// Load/decrement latency counter with a zero flag; used for wake and drain waits.
module clk_gate_lat_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Drives the gating block's active request: sleeps after idle_thresh idle cycles,
// wakes on demand and reports clk_ready once the synchroniser latency has elapsed.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WAKE_LAT = DEF_WAKE_LAT,
    parameter int unsigned OFF_LAT  = DEF_OFF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             wake_req,
    input  logic             force_on,
    input  logic [CNT_W-1:0] idle_thresh,
    output logic             active,
    output logic             clk_ready,
    output logic [1:0]       state
);

    localparam int unsigned WW = lat_w(WAKE_LAT);
    localparam int unsigned DW = lat_w(OFF_LAT);
    localparam logic [WW-1:0] WAKE_LD = WW'(WAKE_LAT - 1);
    localparam logic [DW-1:0] DRAIN_LD = DW'(OFF_LAT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] idle_cnt;
    logic             pending;
    logic             act;
    logic             wake_zero;
    logic             drain_zero;
    logic             wake_start;
    logic             leave_on;

    always_comb begin
        act        = busy | wake_req | force_on;
        // A drain that ends with a request outstanding goes straight back to WAKE.
        wake_start = ((state_q == OFF) && act) ||
                     ((state_q == DRAIN) && drain_zero && (pending || act));
        leave_on   = (state_q == ON) && !act && (idle_thresh != '0) &&
                     (idle_cnt >= (idle_thresh - CNT_W'(1)));
    end

    clk_gate_lat_cnt #(.W(WW)) u_wake_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wake_start),
        .load_val (WAKE_LD),
        .dec      (state_q == WAKE),
        .zero     (wake_zero)
    );

    clk_gate_lat_cnt #(.W(DW)) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (leave_on),
        .load_val (DRAIN_LD),
        .dec      (state_q == DRAIN),
        .zero     (drain_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OFF;
            active    <= 1'b0;
            clk_ready <= 1'b0;
            idle_cnt  <= '0;
            pending   <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (wake_start) begin
                        state_q <= WAKE;
                        active  <= 1'b1;
                    end
                end
                WAKE: begin
                    if (wake_zero) begin
                        state_q   <= ON;
                        clk_ready <= 1'b1;
                    end
                end
                ON: begin
                    if (act) begin
                        idle_cnt <= '0;
                    end else if (leave_on) begin
                        state_q   <= DRAIN;
                        active    <= 1'b0;
                        clk_ready <= 1'b0;
                        idle_cnt  <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (act) begin
                        pending <= 1'b1;
                    end
                    if (drain_zero) begin
                        if (wake_start) begin
                            state_q <= WAKE;
                            active  <= 1'b1;
                            pending <= 1'b0;
                        end else begin
                            state_q <= OFF;
                        end
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with WAKE_LAT=OFF_LAT=3, CNT_W=8.
module tb_clk_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       wake_req;
    logic       force_on;
    logic [7:0] idle_thresh;
    logic       active;
    logic       clk_ready;
    logic [1:0] state;

    int unsigned errors = 0;
    int unsigned checks = 0;

    clk_gate_ctrl #(.CNT_W(8), .WAKE_LAT(3), .OFF_LAT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .busy        (busy),
        .wake_req    (wake_req),
        .force_on    (force_on),
        .idle_thresh (idle_thresh),
        .active      (active),
        .clk_ready   (clk_ready),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected value packed as {state, active, clk_ready}.
    task automatic check(input string tag, input logic [1:0] st, input logic a, input logic r);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {state, active, clk_ready};
        exp = {st, a, r};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: {state,active,clk_ready} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; busy = 1'b0; wake_req = 1'b0; force_on = 1'b0; idle_thresh = 8'd8;
        tick(2);
        check("reset", 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check("idle_off", 2'd0, 1'b0, 1'b0);
        end

        // Wake: active after the sampling edge, clk_ready three edges later.
        wake_req = 1'b1;
        tick(); check("wake_e0", 2'd1, 1'b1, 1'b0);
        tick(); check("wake_e1", 2'd1, 1'b1, 1'b0);
        tick(); check("wake_e2", 2'd1, 1'b1, 1'b0);
        tick(); check("wake_on", 2'd2, 1'b1, 1'b1);
        wake_req = 1'b0;

        // Eight idle edges with threshold 8, then three DRAIN cycles.
        for (int unsigned i = 0; i < 7; i++) begin
            tick();
            check("idle_on", 2'd2, 1'b1, 1'b1);
        end
        tick(); check("sleep_edge", 2'd3, 1'b0, 1'b0);
        tick(); check("drain1", 2'd3, 1'b0, 1'b0);
        tick(); check("drain2", 2'd3, 1'b0, 1'b0);
        tick(); check("drain_off", 2'd0, 1'b0, 1'b0);

        // Busy pulse after five idle edges restarts the idle count.
        wake_req = 1'b1;
        tick(4); check("wake2_on", 2'd2, 1'b1, 1'b1);
        wake_req = 1'b0;
        tick(5); check("idle5", 2'd2, 1'b1, 1'b1);
        busy = 1'b1;
        tick(); check("busy_pulse", 2'd2, 1'b1, 1'b1);
        busy = 1'b0;
        tick(7); check("idle7_after_busy", 2'd2, 1'b1, 1'b1);
        tick(); check("sleep_after_busy", 2'd3, 1'b0, 1'b0);

        // Request one cycle into DRAIN is held pending and resumes straight into WAKE.
        tick(); check("drain_d1", 2'd3, 1'b0, 1'b0);
        wake_req = 1'b1;
        tick(); check("drain_pend", 2'd3, 1'b0, 1'b0);
        tick(); check("drain_to_wake", 2'd1, 1'b1, 1'b0);
        tick(); check("pend_wake1", 2'd1, 1'b1, 1'b0);
        tick(); check("pend_wake2", 2'd1, 1'b1, 1'b0);
        tick(); check("pend_on", 2'd2, 1'b1, 1'b1);

        // force_on with threshold 1 keeps the domain up; first idle edge then sleeps.
        idle_thresh = 8'd1; force_on = 1'b1; wake_req = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check("force_on", 2'd2, 1'b1, 1'b1);
        end
        force_on = 1'b0;
        tick(); check("thresh1_sleep", 2'd3, 1'b0, 1'b0);
        tick(3); check("thresh1_off", 2'd0, 1'b0, 1'b0);

        // Threshold 0 never sleeps, even past idle counter saturation.
        idle_thresh = 8'd0; wake_req = 1'b1;
        tick(4); check("wake3_on", 2'd2, 1'b1, 1'b1);
        wake_req = 1'b0;
        for (int unsigned i = 0; i < 300; i++) begin
            tick();
            check("thresh0", 2'd2, 1'b1, 1'b1);
        end
        // Lowering the threshold below the current count sleeps on the next idle edge.
        idle_thresh = 8'd5;
        tick(); check("thresh_drop", 2'd3, 1'b0, 1'b0);
        tick(3); check("thresh_drop_off", 2'd0, 1'b0, 1'b0);

        // Asynchronous reset during WAKE clears everything without a clock edge.
        idle_thresh = 8'd8; wake_req = 1'b1;
        tick(); check("wake4", 2'd1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst", 2'd0, 1'b0, 1'b0);
        wake_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check("post_rst", 2'd0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
